req_arbiter_4: RTL and testbench
================================

// Module: req_arbiter_4
//
// PURPOSE
//   Sequential 4-requester arbiter that shares one resource using priority-encoder selection.
//   Supports fixed priority (req[3] highest) or round-robin, selected by rr_en.
//   Holds a grant until the owner releases it, or until the hold limit expires while others wait.
//   Sits between up to four requesting blocks and a single shared resource (bus/port).
//
// PARAMETERS
//   MAX_HOLD   8   max consecutive grant cycles before forced release when others are pending (>=2)
//   HOLD_W     4   width of hold counter; must satisfy 2**HOLD_W > MAX_HOLD
//
// PORTS
//   clk          in   1  single clock, rising edge
//   rst          in   1  asynchronous, active-high reset
//   req          in   4  request lines, level-sensitive; req[i] high = requester i wants resource
//   rr_en        in   1  1 = round-robin, 0 = fixed priority; sampled only when arbitrating
//   grant        out  4  one-hot grant, registered; all-zero when idle
//   grant_id     out  2  index of current/last winner, registered
//   grant_valid  out  1  high while any grant bit is high (equals |grant)
//
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, grant=4'b0000, grant_id=2'd0, grant_valid=0,
//     rr_ptr=2'd3, hold_cnt=0.
//   - States: IDLE, GRANT.
//   - IDLE: if |req, pick winner w. Next edge: grant=1<<w, grant_id=w, grant_valid=1,
//     hold_cnt=1, state=GRANT. Latency: req sampled high -> grant high 1 cycle later.
//   - Search order:
//     - fixed: 3,2,1,0.
//     - round-robin: rr_ptr, rr_ptr-1, ... (mod 4).
//     - On each new grant to w: rr_ptr <= w-1 (mod 4, natural 2-bit wrap).
//     - After reset, round-robin order equals fixed order.
//   - GRANT, owner request dropped: if req[grant_id]==0 at an edge -> grant=0, grant_valid=0,
//     state=IDLE. There is one dead cycle minimum between successive grants.
//   - GRANT, hold limit:
//     - If hold_cnt==MAX_HOLD and any other req bit high -> forced release, same as a drop.
//     - If hold_cnt==MAX_HOLD and no other req -> keep grant, hold_cnt <= 1.
//     - Otherwise hold_cnt increments and saturates (never wraps).
//   - Non-owner requests that rise and fall during GRANT are not latched; they are only
//     considered if still high in IDLE.
//   - rr_en changes during GRANT have no effect until the next arbitration.
//   - Owner drop and hold expiry on the same edge: treat as a normal release; rr_ptr is
//     already updated.
//   - grant_id holds the last winner while idle; consumers qualify it with grant_valid.
//   - grant is never multi-hot. Any illegal state encoding recovers to IDLE with grant=0.
//
// STRUCTURE
//   - Shared include arb_defs.vh:
//     - localparams ST_IDLE=1'b0, ST_GRANT=1'b1.
//     - NUM_REQ=4.
//     - ID_W=2.
//   - Sub-module prio_pick_4 (combinational):
//     - inputs req[3:0], start[1:0]; outputs id[1:0], any.
//     - Rotated priority encoder; fixed mode drives start=2'd3.
//   - Top module: state register, rr_ptr, hold_cnt, and output registers in one always block
//     with posedge clk, posedge rst.
//
// TESTING
//   1. rst=1 then 0, req=0000 for 5 cycles -> grant=0000, grant_valid=0, grant_id=0 throughout.
//   2. Fixed mode, req=1111 held -> grant=1000 one cycle after req; held 8 cycles; then 1 dead
//      cycle; then grant=1000 again (fixed, no rotation).
//   3. rr_en=1, req=1111 held -> grant sequence 1000,0100,0010,0001,1000, each 8 cycles with
//      1 dead cycle between.
//   4. rr_en=0, req=0010 only for 20 cycles -> grant=0010 continuous, no forced release at
//      hold limit.
//   5. Grant to 0100, then req[2] drops while req[0]=1 -> grant=0000 next edge, grant=0001
//      the edge after.
//   6. Assert rst mid-GRANT (grant=0100) between edges -> grant=0000 immediately; after
//      release, req=1111 in RR mode gives grant=1000 first.

Source files
------------

// File: rtl/req_arbiter_4_pkg.sv
// Shared definitions for the 4-requester arbiter: requester count, id width
// and the two-state arbitration FSM encoding.
package req_arbiter_4_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/req_arbiter_4_pick.sv
// Rotated priority encoder: searches start, start-1, ... (mod 4) and returns the
// first requester found. Fixed priority is the special case start = 3.
module prio_pick_4
    import req_arbiter_4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    logic [ID_W-1:0] cand;

    // Walk from the lowest-priority slot up so the last hit is the highest priority.
    always_comb begin
        id   = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = start - ID_W'(i);
            if (req[cand]) begin
                id  = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_arbiter_4.sv
// Four-requester arbiter with fixed or round-robin priority, grant held until the
// owner releases or the hold limit expires while another requester is waiting.
module req_arbiter_4
    import req_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rr_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [NUM_REQ-1:0]  grant_nxt;
    logic [ID_W-1:0]     grant_id_nxt;
    logic [ID_W-1:0]     pick_start;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic                owner_req;
    logic                others_req;
    logic                at_limit;

    assign pick_start = rr_en ? rr_ptr : ID_W'(NUM_REQ - 1);

    prio_pick_4 u_pick (
        .req   (req),
        .start (pick_start),
        .id    (pick_id),
        .any   (pick_any)
    );

    assign owner_req  = req[grant_id];
    assign others_req = |(req & ~grant);
    assign at_limit   = (hold_cnt == HOLD_W'(MAX_HOLD));

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        rr_ptr_nxt   = rr_ptr;
        hold_cnt_nxt = hold_cnt;
        case (state)
            ST_IDLE: begin
                grant_nxt = '0;
                if (pick_any) begin
                    state_nxt    = ST_GRANT;
                    grant_nxt    = NUM_REQ'(1) << pick_id;
                    grant_id_nxt = pick_id;
                    rr_ptr_nxt   = pick_id - ID_W'(1);
                    hold_cnt_nxt = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                // A drop and a limit expiry on the same edge are one ordinary release.
                if (!owner_req || (at_limit && others_req)) begin
                    state_nxt    = ST_IDLE;
                    grant_nxt    = '0;
                    hold_cnt_nxt = '0;
                end else if (at_limit) begin
                    hold_cnt_nxt = HOLD_W'(1);
                end else if (hold_cnt < HOLD_W'(MAX_HOLD)) begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                grant_nxt    = '0;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_id    <= grant_id_nxt;
            grant_valid <= |grant_nxt;
            rr_ptr      <= rr_ptr_nxt;
            hold_cnt    <= hold_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_req_arbiter_4.sv
// Self-checking bench for req_arbiter_4: directed scenarios plus randomized
// traffic compared against a behavioural ownership model.
module tb_req_arbiter_4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       rr_en = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: who owns the resource and for how long.
    int m_owner;
    int m_held;
    int m_last;
    int m_start;

    req_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rr_en       (rr_en),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 0;
        m_start = 3;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rr);
        int first;
        int idx;
        bit others;
        if (m_owner < 0) begin
            first = rr ? m_start : 3;
            for (int k = 0; k < 4; k++) begin
                idx = (first - k + 4) % 4;
                if (r[idx] && m_owner < 0) m_owner = idx;
            end
            if (m_owner >= 0) begin
                m_held  = 1;
                m_last  = m_owner;
                m_start = (m_owner + 3) % 4;
            end
        end else begin
            others = 1'b0;
            for (int k = 0; k < 4; k++)
                if (k != m_owner && r[k]) others = 1'b1;
            if (!r[m_owner] || (m_held == MAX_HOLD && others)) begin
                m_owner = -1;
                m_held  = 0;
            end else if (m_held == MAX_HOLD) begin
                m_held = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    function automatic logic [3:0] model_grant();
        return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    endfunction

    task automatic tick();
        logic [3:0] r;
        logic       rr;
        r  = req;
        rr = rr_en;
        @(posedge clk);
        model_edge(r, rr);
        #1;
        check("model_grant", 32'(grant), 32'(model_grant()));
        check("model_id", 32'(grant_id), 32'(m_last));
        check("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_id", 32'(grant_id), 32'h0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_g;
        int pos;
        int per;
        model_reset();

        // Idle after reset
        req = 4'b0000;
        rr_en = 1'b0;
        async_reset();
        for (int t = 0; t < 5; t++) begin
            tick();
            check("idle_grant", 32'(grant), 32'h0);
        end

        // Fixed priority, all requesting: 8 cycles, dead cycle, same winner again
        rr_en = 1'b0;
        req = 4'b1111;
        for (int t = 1; t <= 10; t++) begin
            tick();
            exp_g = (t == 9) ? 4'b0000 : 4'b1000;
            check("fixed_hold", 32'(grant), 32'(exp_g));
        end

        // Round-robin rotation
        req = 4'b0000;
        async_reset();
        rr_en = 1'b1;
        req = 4'b1111;
        for (int t = 1; t <= 45; t++) begin
            tick();
            pos = (t - 1) % 9;
            per = (t - 1) / 9;
            exp_g = (pos == 8) ? 4'b0000 : (4'b1000 >> (per % 4));
            check("rr_seq", 32'(grant), 32'(exp_g));
        end

        // Lone requester is never forced off
        req = 4'b0000;
        async_reset();
        rr_en = 1'b0;
        req = 4'b0010;
        for (int t = 1; t <= 20; t++) begin
            tick();
            check("lone_hold", 32'(grant), 32'h2);
        end

        // Owner drop hands over after one dead cycle
        req = 4'b0000;
        async_reset();
        req = 4'b0101;
        tick();
        check("drop_first", 32'(grant), 32'h4);
        req = 4'b0001;
        tick();
        check("drop_dead", 32'(grant), 32'h0);
        tick();
        check("drop_next", 32'(grant), 32'h1);
        check("drop_id", 32'(grant_id), 32'h0);

        // Async reset mid-grant, then round-robin starts from requester 3
        req = 4'b0000;
        async_reset();
        req = 4'b0100;
        tick();
        check("mid_grant", 32'(grant), 32'h4);
        async_reset();
        rr_en = 1'b1;
        req = 4'b1111;
        tick();
        check("post_rst_rr", 32'(grant), 32'h8);

        // Randomized traffic
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) rr_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) async_reset();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
